// File: rtl/cause_collector_if.sv
// cause_collector_if
//   Bundles every signal exchanged between the cause collector and its
//   neighbours (external request lines, internal exception events, the
//   interrupt-stage acknowledge path and the interval timer control).
//   clk and rst remain plain ports on the module that uses this bundle.
//
//   Parameter
//     TIMER_W  width of the interval timer counter / reload value
//
//   Signals
//     ext_irq[14:0]     asynchronous external request lines
//     ev_valid          internal event strobe qualifier
//     ev_ill .. ev_ovf  one-shot internal exception events
//     jisr              interrupt taken this cycle
//     mca[22:0]         masked cause vector fed back for acknowledge
//     tmr_wr, tmr_val   timer reload/counter load
//     tmr_en            timer count enable
//     ca[22:0]          registered cause vector
//     tmr_cnt           current timer count
//
//   Modports
//     master  side that drives the requests and consumes the cause vector
//     slave   the cause collector itself
interface cause_collector_if #(
  parameter int TIMER_W = 32
);
  logic [14:0]        ext_irq;
  logic               ev_valid;
  logic               ev_ill;
  logic               ev_mal;
  logic               ev_pff;
  logic               ev_pfls;
  logic               ev_sysc;
  logic               ev_ovf;
  logic               jisr;
  logic [22:0]        mca;
  logic               tmr_wr;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic [22:0]        ca;
  logic [TIMER_W-1:0] tmr_cnt;

  modport master (
    output ext_irq, ev_valid, ev_ill, ev_mal, ev_pff, ev_pfls, ev_sysc, ev_ovf,
    output jisr, mca, tmr_wr, tmr_val, tmr_en,
    input  ca, tmr_cnt
  );

  modport slave (
    input  ext_irq, ev_valid, ev_ill, ev_mal, ev_pff, ev_pfls, ev_sysc, ev_ovf,
    input  jisr, mca, tmr_wr, tmr_val, tmr_en,
    output ca, tmr_cnt
  );
endinterface

// File: rtl/cause_collector.sv
// cause_collector
//   Gathers every interrupt source into the 23-bit cause vector ca:
//     ca[0]      reset cause, sticky until acknowledged
//     ca[6:1]    ill, mal, pff, pfls, sysc, ovf -- one-cycle copies of the
//                qualified internal events, never sticky
//     ca[7]      interval timer expiry, sticky until acknowledged
//     ca[22:8]   rising edges of the synchronised external lines, sticky
//   A sticky bit is acknowledged by jisr together with the matching mca bit;
//   a new set in the same cycle as its acknowledge keeps the bit high.
//
//   Parameters
//     TIMER_W      timer counter / reload width
//     SYNC_STAGES  synchroniser depth for the external lines (>= 2)
//
//   Ports
//     clk  system clock, rising edge
//     rst  asynchronous active-low reset
//     bus  cause_collector_if.slave (requests in, ca / tmr_cnt out)
//
//   Build option
//     CAUSE_TIMER_EN  defined: interval timer and reload register are built.
//                     undefined: ca[7] and tmr_cnt are tied to 0 and the
//                     timer controls are ignored.
module cause_collector #(
  parameter int TIMER_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  cause_collector_if.slave bus
);

  localparam int N_EXT = 15;

  logic [SYNC_STAGES-1:0][N_EXT-1:0] sync_q;
  logic [N_EXT-1:0]                  ext_s;
  logic [N_EXT-1:0]                  ext_prev_q;
  logic [N_EXT-1:0]                  ext_rise;
  logic [22:0]                       ack;
  logic [22:0]                       ca_q;
  logic [22:0]                       ca_d;
  logic                              tmr_ca_d;
  logic                              unused_ack;

  // Acknowledge mask: only meaningful in the cycle an interrupt is taken.
  assign ack = {23{bus.jisr}} & bus.mca;

  // Internal causes are reloaded every cycle, so their ack bits are unused.
  assign unused_ack = ^ack[6:1];

  // ---- synchroniser + edge detector ----------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      ext_prev_q <= '0;
    end else begin
      sync_q[0] <= bus.ext_irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      ext_prev_q <= ext_s;
    end
  end

  assign ext_s    = sync_q[SYNC_STAGES-1];
  // A held level produces a single event: only the 0->1 step is reported.
  assign ext_rise = ext_s & ~ext_prev_q;

`ifdef CAUSE_TIMER_EN
  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] reload_q;
  logic               expire;

  // Expiry is the 1->0 step of an enabled count; a write in the same cycle
  // takes priority and suppresses it.
  assign expire = !bus.tmr_wr && bus.tmr_en && (cnt_q == TIMER_W'(1));

  // ---- interval timer ------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else if (bus.tmr_wr) begin
      cnt_q    <= bus.tmr_val;
      reload_q <= bus.tmr_val;
    end else if (bus.tmr_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end else if ((cnt_q == '0) && (reload_q != '0)) begin
      // A zero count with a nonzero reload only occurs the cycle after an
      // expiry, giving a period of reload+1 cycles. A zero reload parks the
      // counter at 0 with no further expiries.
      cnt_q <= reload_q;
    end
  end

  assign tmr_ca_d    = expire | (ca_q[7] & ~ack[7]);
  assign bus.tmr_cnt = cnt_q;
`else
  logic unused_tmr;

  assign unused_tmr  = ^{bus.tmr_wr, bus.tmr_val, bus.tmr_en, ack[7]};
  assign tmr_ca_d    = 1'b0;
  assign bus.tmr_cnt = '0;
`endif

  // ---- cause vector next state ---------------------------------------------
  always_comb begin
    ca_d       = '0;
    ca_d[0]    = ca_q[0] & ~ack[0];
    ca_d[6:1]  = {6{bus.ev_valid}} &
                 {bus.ev_ovf, bus.ev_sysc, bus.ev_pfls,
                  bus.ev_pff, bus.ev_mal, bus.ev_ill};
    ca_d[7]    = tmr_ca_d;
    // Set is ORed after the clear so a same-cycle set wins over the ack.
    ca_d[22:8] = ext_rise | (ca_q[22:8] & ~ack[22:8]);
  end

  // ---- cause register ------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ca_q <= 23'h000001;
    end else begin
      ca_q <= ca_d;
    end
  end

  assign bus.ca = ca_q;

endmodule

// File: tb/tb_cause_collector.sv
// tb_cause_collector
//   Self-checking bench for cause_collector. A behavioural model tracks the
//   cause vector and timer from the documented rules (external edges are
//   derived from a history of sampled line values delayed by the
//   synchroniser depth). Scenario tasks run in sequence and compare the DUT
//   against the model and against hand-derived constants.
module tb_cause_collector;

  localparam int TW = 32;
  localparam int SS = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cause_collector_if #(.TIMER_W(TW)) bus ();

  cause_collector #(.TIMER_W(TW), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [22:0]   m_ca;
  logic [TW-1:0] m_cnt;
  logic [TW-1:0] m_reload;
  logic [14:0]   m_ext_q[$];

  task automatic model_reset();
    m_ca     = 23'h000001;
    m_cnt    = '0;
    m_reload = '0;
    m_ext_q.delete();
    for (int i = 0; i <= SS; i++) m_ext_q.push_back(15'h0);
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [22:0] a;
    logic [22:0] n;
    logic [14:0] rise;
    a    = bus.jisr ? bus.mca : 23'h0;
    // m_ext_q[j] holds the line value sampled j+1 edges ago.
    rise = m_ext_q[SS-1] & ~m_ext_q[SS];
    n[0]    = m_ca[0] & ~a[0];
    n[6:1]  = bus.ev_valid ? {bus.ev_ovf, bus.ev_sysc, bus.ev_pfls,
                              bus.ev_pff, bus.ev_mal, bus.ev_ill} : 6'h0;
    n[22:8] = rise | (m_ca[22:8] & ~a[22:8]);
`ifdef CAUSE_TIMER_EN
    n[7] = (!bus.tmr_wr && bus.tmr_en && m_cnt == 1) | (m_ca[7] & ~a[7]);
    if (bus.tmr_wr) begin
      m_cnt    = bus.tmr_val;
      m_reload = bus.tmr_val;
    end else if (bus.tmr_en && m_cnt != 0) begin
      m_cnt = m_cnt - 1;
    end else if (m_cnt == 0 && m_reload != 0) begin
      m_cnt = m_reload;
    end
`else
    n[7] = 1'b0;
`endif
    m_ca = n;
    m_ext_q.push_front(bus.ext_irq);
    void'(m_ext_q.pop_back());
  endtask

  // One clock: inputs sampled at the rising edge, outputs observed at the
  // following falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ext_irq  = '0;
    bus.ev_valid = 1'b0;
    bus.ev_ill   = 1'b0;
    bus.ev_mal   = 1'b0;
    bus.ev_pff   = 1'b0;
    bus.ev_pfls  = 1'b0;
    bus.ev_sysc  = 1'b0;
    bus.ev_ovf   = 1'b0;
    bus.jisr     = 1'b0;
    bus.mca      = '0;
    bus.tmr_wr   = 1'b0;
    bus.tmr_val  = '0;
    bus.tmr_en   = 1'b0;
  endtask

  // Clear everything pending so the next scenario starts from ca == 0.
  task automatic quiesce();
    idle_inputs();
    for (int i = 0; i < SS + 2; i++) step();
    bus.jisr = 1'b1;
    bus.mca  = '1;
    step();
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.ca !== 23'h000001) begin
      n_fail++;
      $display("FAIL reset_ca_held: got %h, required %h", bus.ca, 23'h000001);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ca !== 23'h000001) begin
      n_fail++;
      $display("FAIL reset_ca_release: got %h, required %h", bus.ca, 23'h000001);
    end
    n_checks++;
    if (bus.tmr_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_tmr_cnt: got %0d, required 0", bus.tmr_cnt);
    end
    @(negedge clk);
    bus.jisr = 1'b1;
    bus.mca  = 23'h000001;
    step();
    idle_inputs();
    n_checks++;
    if (bus.ca !== 23'h000000 || m_ca !== 23'h000000) begin
      n_fail++;
      $display("FAIL reset_ack: got %h (model %h), required 000000", bus.ca, m_ca);
    end
  endtask

  task automatic test_ext_hold();
    bus.ext_irq[3] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_checks++;
      if (bus.ca[11] !== (c >= SS + 1) || bus.ca !== m_ca) begin
        n_fail++;
        $display("FAIL ext_hold_c%0d: got ca=%h, required ca[11]=%0d model=%h",
                 c, bus.ca, (c >= SS + 1), m_ca);
      end
    end
    bus.jisr = 1'b1;
    bus.mca  = 23'h1 << 11;
    step();
    bus.jisr = 1'b0;
    bus.mca  = '0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (bus.ca !== 23'h0 || m_ca !== 23'h0) begin
        n_fail++;
        $display("FAIL ext_ack_held_c%0d: got %h (model %h), required 000000", c, bus.ca, m_ca);
      end
      step();
    end
    quiesce();
  endtask

  task automatic test_internal();
    bus.ev_valid = 1'b1;
    bus.ev_sysc  = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (bus.ca !== 23'h000020) begin
      n_fail++;
      $display("FAIL ev_sysc_set: got %h, required 000020", bus.ca);
    end
    step();
    n_checks++;
    if (bus.ca !== 23'h000000) begin
      n_fail++;
      $display("FAIL ev_sysc_one_cycle: got %h, required 000000", bus.ca);
    end
    bus.ev_sysc = 1'b1;
    bus.ev_ill  = 1'b1;
    step();
    n_checks++;
    if (bus.ca !== 23'h000000) begin
      n_fail++;
      $display("FAIL ev_unqualified: got %h, required 000000", bus.ca);
    end
    bus.ev_valid = 1'b1;
    bus.ev_ovf   = 1'b1;
    bus.jisr     = 1'b1;
    bus.mca      = 23'h7E;
    step();
    idle_inputs();
    n_checks++;
    if (bus.ca !== 23'h000062) begin
      n_fail++;
      $display("FAIL ev_multi_jisr: got %h, required 000062", bus.ca);
    end
    step();
  endtask

  task automatic test_timer();
`ifdef CAUSE_TIMER_EN
    int k;
    int k2;
    bus.tmr_wr  = 1'b1;
    bus.tmr_val = 5;
    bus.tmr_en  = 1'b1;
    step();
    bus.tmr_wr = 1'b0;
    n_checks++;
    if (bus.tmr_cnt !== 5) begin
      n_fail++;
      $display("FAIL tmr_load: got %0d, required 5", bus.tmr_cnt);
    end
    k = 0;
    while (bus.ca[7] !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (k !== 5 || bus.tmr_cnt !== 0) begin
      n_fail++;
      $display("FAIL tmr_first_expiry: got %0d cycles cnt=%0d, required 5 cycles cnt=0", k, bus.tmr_cnt);
    end
    bus.jisr = 1'b1;
    bus.mca  = 23'h80;
    step();
    bus.jisr = 1'b0;
    bus.mca  = '0;
    n_checks++;
    if (bus.tmr_cnt !== 5 || bus.ca[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL tmr_reload: got cnt=%0d ca7=%b, required cnt=5 ca7=0", bus.tmr_cnt, bus.ca[7]);
    end
    k2 = 1;
    while (bus.ca[7] !== 1'b1 && k2 < 20) begin
      step();
      k2++;
    end
    n_checks++;
    if (k2 !== 6 || bus.ca !== m_ca) begin
      n_fail++;
      $display("FAIL tmr_period: got %0d cycles ca=%h, required 6 cycles ca=%h", k2, bus.ca, m_ca);
    end
    bus.tmr_wr  = 1'b1;
    bus.tmr_val = 0;
    step();
    bus.tmr_wr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        bus.jisr = 1'b1;
        bus.mca  = 23'h80;
      end else begin
        bus.jisr = 1'b0;
      end
      step();
      n_checks++;
      if (bus.tmr_cnt !== 0 || bus.ca[7] !== 1'b0) begin
        n_fail++;
        $display("FAIL tmr_zero_reload_c%0d: got cnt=%0d ca7=%b, required 0 0", c, bus.tmr_cnt, bus.ca[7]);
      end
    end
    quiesce();
`else
    for (int c = 0; c < 40; c++) begin
      bus.tmr_wr  = ($urandom_range(0, 3) == 0);
      bus.tmr_val = $urandom_range(0, 4);
      bus.tmr_en  = 1'b1;
      step();
      n_checks++;
      if (bus.ca[7] !== 1'b0 || bus.tmr_cnt !== 0) begin
        n_fail++;
        $display("FAIL tmr_absent_c%0d: got ca7=%b cnt=%0d, required 0 0", c, bus.ca[7], bus.tmr_cnt);
      end
    end
    quiesce();
`endif
  endtask

  task automatic test_collision();
    bus.ext_irq[0] = 1'b1;
    repeat (SS + 2) step();
    bus.ext_irq[0] = 1'b0;
    repeat (SS + 2) step();
    n_checks++;
    if (bus.ca[8] !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_pending: got ca[8]=%b, required 1", bus.ca[8]);
    end
    bus.ext_irq[0] = 1'b1;
    repeat (SS) step();
    bus.jisr = 1'b1;
    bus.mca  = 23'h1 << 8;
    step();
    bus.jisr = 1'b0;
    n_checks++;
    if (bus.ca[8] !== 1'b1 || bus.ca !== m_ca) begin
      n_fail++;
      $display("FAIL coll_set_wins: got ca=%h, required ca[8]=1 model=%h", bus.ca, m_ca);
    end
    bus.jisr = 1'b1;
    step();
    bus.jisr = 1'b0;
    n_checks++;
    if (bus.ca[8] !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_ack_after: got ca[8]=%b, required 0", bus.ca[8]);
    end
    quiesce();
  endtask

  task automatic test_random();
    logic [14:0] flip;
    for (int c = 0; c < 400; c++) begin
      flip         = 15'($urandom & $urandom & $urandom);
      bus.ext_irq  = bus.ext_irq ^ flip;
      bus.ev_valid = 1'($urandom_range(0, 1));
      bus.ev_ill   = 1'($urandom_range(0, 1));
      bus.ev_mal   = 1'($urandom_range(0, 1));
      bus.ev_pff   = 1'($urandom_range(0, 1));
      bus.ev_pfls  = 1'($urandom_range(0, 1));
      bus.ev_sysc  = 1'($urandom_range(0, 1));
      bus.ev_ovf   = 1'($urandom_range(0, 1));
      bus.jisr     = ($urandom_range(0, 3) == 0);
      bus.mca      = 23'($urandom);
      bus.tmr_wr   = ($urandom_range(0, 15) == 0);
      bus.tmr_val  = $urandom_range(0, 6);
      bus.tmr_en   = ($urandom_range(0, 7) != 0);
      step();
      n_checks++;
      if (bus.ca !== m_ca || bus.tmr_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL random_c%0d: got ca=%h cnt=%0d, required ca=%h cnt=%0d",
                 c, bus.ca, bus.tmr_cnt, m_ca, m_cnt);
      end
    end
    quiesce();
  endtask

  task automatic test_async_reset();
    bus.ext_irq[7] = 1'b1;
`ifdef CAUSE_TIMER_EN
    bus.tmr_wr  = 1'b1;
    bus.tmr_val = 3;
    step();
    bus.tmr_wr = 1'b0;
    repeat (SS) step();
    n_checks++;
    if (bus.tmr_cnt !== 3) begin
      n_fail++;
      $display("FAIL arst_pre_cnt: got %0d, required 3", bus.tmr_cnt);
    end
`else
    repeat (SS + 1) step();
`endif
    n_checks++;
    if (bus.ca[15] !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre_pending: got ca[15]=%b, required 1", bus.ca[15]);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.ca !== 23'h000001 || bus.tmr_cnt !== 0) begin
      n_fail++;
      $display("FAIL arst_immediate: got ca=%h cnt=%0d, required 000001 0", bus.ca, bus.tmr_cnt);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (bus.ca !== m_ca || bus.ca !== 23'h000001) begin
        n_fail++;
        $display("FAIL arst_after_c%0d: got ca=%h, required 000001", c, bus.ca);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle_inputs();
    test_reset();
    test_ext_hold();
    test_internal();
    test_timer();
    test_collision();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
